// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - opcodes and FSM state encoding for the MIPS execute unit
package mips_alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1101;
    localparam logic [3:0] OP_MULTU = 4'b1110;
    localparam logic [3:0] OP_DIVU  = 4'b1111;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

endpackage

// File: rtl/mips_alu_md_if.sv
// rtl/mips_alu_md_if.sv - operation/result handshake bundle of the execute unit
interface mips_alu_md_if #(parameter int WIDTH = 32);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_operation;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [SHW-1:0]   shmt;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             ZERO;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output in_valid, alu_operation, in1, in2, shmt,
                    input  in_ready, out_valid, out, ZERO, hi, lo);
    modport slave  (input  in_valid, alu_operation, in1, in2, shmt,
                    output in_ready, out_valid, out, ZERO, hi, lo);
endinterface

// File: rtl/mips_md_iter.sv
// rtl/mips_md_iter.sv - iterative shift-add multiplier / restoring divider with sign fixup
module mips_md_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             run,
    input  logic             fix,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    logic [WIDTH-1:0] acc, q, m;
    logic [SHW-1:0]   cnt;
    logic             is_div, neg_lo, neg_hi;
    logic [WIDTH-1:0] a_mag, b_mag, sub;
    logic [WIDTH:0]   add, shifted;
    logic             ge;

    always_comb begin
        a_mag   = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag   = (op_signed && b[WIDTH-1]) ? -b : b;
        add     = q[0] ? ({1'b0, acc} + {1'b0, m}) : {1'b0, acc};
        shifted = {acc, q[WIDTH-1]};
        ge      = shifted >= {1'b0, m};
        // partial remainder is always below the divisor, so W bits suffice
        sub     = shifted[WIDTH-1:0] - m;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            q      <= a_mag;
            m      <= b_mag;
            cnt    <= SHW'(WIDTH - 1);
            is_div <= op_div;
            // a zero divisor leaves the all-ones quotient unsigned and hi equal to in1
            neg_lo <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && (!op_div || (b != '0));
            neg_hi <= op_signed && a[WIDTH-1] && op_div;
        end else if (run) begin
            cnt <= cnt - 1'b1;
            if (is_div) begin
                acc <= ge ? sub : shifted[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], ge};
            end else begin
                acc <= add[WIDTH:1];
                q   <= {add[0], q[WIDTH-1:1]};
            end
        end else if (fix) begin
            if (is_div) begin
                if (neg_lo) q   <= -q;
                if (neg_hi) acc <= -acc;
            end else if (neg_lo) begin
                {acc, q} <= -{acc, q};
            end
        end
    end

    assign last   = (cnt == '0);
    assign res_hi = acc;
    assign res_lo = q;
endmodule

// File: rtl/mips_alu_md.sv
// rtl/mips_alu_md.sv - MIPS execute unit: single-cycle ALU plus iterative mult/div with HI/LO
module mips_alu_md
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    mips_alu_md_if.slave  bus
);
    state_t           state, state_nx;
    logic             accept, is_md, md_div, md_signed, last;
    logic [3:0]       op;
    logic [WIDTH-1:0] in1, in2, alu_res, res_hi, res_lo;
    logic [WIDTH-1:0] out_q, hi_q, lo_q;
    logic             out_valid_q, zero_q;

    assign op        = bus.alu_operation;
    assign in1       = bus.in1;
    assign in2       = bus.in2;
    assign accept    = bus.in_valid && bus.in_ready;
    assign is_md     = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_MULT) || (op == OP_MULTU);
    assign md_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign md_signed = (op == OP_DIV) || (op == OP_MULT);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = in1 & in2;
            OP_OR:   alu_res = in1 | in2;
            OP_ADD:  alu_res = in1 + in2;
            OP_SUB:  alu_res = in1 - in2;
            OP_SLL:  alu_res = in2 << bus.shmt;
            OP_SRL:  alu_res = in2 >> bus.shmt;
            OP_SRA:  alu_res = $signed(in2) >>> bus.shmt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, in1 < in2};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_NOR:  alu_res = ~(in1 | in2);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_md) state_nx = md_div ? DIV : MUL;
            MUL,
            DIV:     if (last) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zero_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state       <= state_nx;
            out_valid_q <= 1'b0;
            if (accept && !is_md) begin
                out_q       <= alu_res;
                zero_q      <= (alu_res == '0);
                out_valid_q <= 1'b1;
            end
            if (state == DONE) begin
                hi_q        <= res_hi;
                lo_q        <= res_lo;
                out_q       <= res_lo;
                zero_q      <= (res_lo == '0);
                out_valid_q <= 1'b1;
            end
        end
    end

    mips_md_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (accept && is_md),
        .op_div    (md_div),
        .op_signed (md_signed),
        .a         (in1),
        .b         (in2),
        .run       ((state == MUL) || (state == DIV)),
        .fix       (state == FIX),
        .last      (last),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.ZERO      = zero_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mips_alu_md.sv
// tb/tb_mips_alu_md.sv - scoreboard bench for mips_alu_md (WIDTH 32 and 16)
module tb_mips_alu_md;
    import mips_alu_pkg::*;

    typedef struct packed {
        logic [31:0] out;
        logic        z;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic reset, rst16;
    always #5 clk = ~clk;

    mips_alu_md_if #(.WIDTH(32)) bus();
    mips_alu_md_if #(.WIDTH(16)) bus16();

    mips_alu_md #(.WIDTH(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
    mips_alu_md #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst16), .bus(bus16));

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // monitor: every output pulse is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got out=%h, required no output", bus.out);
            end else begin
                e = sb.pop_front();
                chk("out",  bus.out, e.out);
                chk("zero", 32'(bus.ZERO), 32'(e.z));
                chk("hi",   bus.hi, e.hi);
                chk("lo",   bus.lo, e.lo);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit push, input exp_t e, output int waits);
        @(negedge clk);
        bus.alu_operation = op;
        bus.in1           = a;
        bus.in2           = b;
        bus.shmt          = sh;
        bus.in_valid      = 1'b1;
        waits = 0;
        while (bus.in_ready !== 1'b1 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 100) begin
            chk("accept_timeout", 32'(waits), 32'd0);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) sb.push_back(e);
        end
    endtask

    task automatic sc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [31:0] exp_out, output int waits);
        exp_t e;
        e.out = exp_out;
        e.z   = (exp_out == 32'd0);
        e.hi  = mhi;
        e.lo  = mlo;
        send(op, a, b, sh, 1'b1, e, waits);
    endtask

    task automatic wait_idle(input bit hold, output int n);
        bit done = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!hold) bus.in_valid = 1'b0;
            if (bus.in_ready === 1'b1) begin
                bus.in_valid = 1'b0;
                done = 1'b1;
            end else begin
                n++;
            end
        end
        if (!done) chk("busy_timeout", 32'(n), 32'd34);
    endtask

    task automatic md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit hold);
        exp_t e;
        int   w, n;
        e.out = exp_lo;
        e.z   = (exp_lo == 32'd0);
        e.hi  = exp_hi;
        e.lo  = exp_lo;
        send(op, a, b, 5'd0, 1'b1, e, w);
        mhi = exp_hi;
        mlo = exp_lo;
        wait_idle(hold, n);
        chk("busy_cycles", 32'(n), 32'd34);
        chk("done_pulse", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        int   w, wsum, n;
        bit   done;
        exp_t dummy;
        dummy = '0;
        reset = 1'b1;
        rst16 = 1'b1;
        bus.in_valid = 1'b0;   bus.alu_operation = OP_AND;
        bus.in1 = '0;          bus.in2 = '0;          bus.shmt = '0;
        bus16.in_valid = 1'b0; bus16.alu_operation = OP_AND;
        bus16.in1 = '0;        bus16.in2 = '0;        bus16.shmt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rst16 = 1'b0;
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out",       bus.out, 32'd0);
        chk("rst_zero",      32'(bus.ZERO), 32'd0);
        chk("rst_hi",        bus.hi, 32'd0);
        chk("rst_lo",        bus.lo, 32'd0);

        // wraparound add, zero flag set then recomputed
        sc(OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, w);
        sc(OP_SUB, 32'h5, 32'h5, 5'd0, 32'h0, w);
        sc(OP_OR,  32'h0F, 32'hF0, 5'd0, 32'hFF, w);
        sc(OP_AND, 32'h0F, 32'hF0, 5'd0, 32'h0, w);
        sc(OP_AND, 32'h0F, 32'hFF, 5'd0, 32'h0F, w);

        // back-to-back shifts and compares at full rate
        wsum = 0;
        sc(OP_SLL,  32'h0, 32'h1,        5'd4, 32'h10,       w); wsum += w;
        sc(OP_SRA,  32'h0, 32'hF0000000, 5'd4, 32'hFF000000, w); wsum += w;
        sc(OP_SLTU, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h1,        w); wsum += w;
        sc(OP_SLT,  32'h1, 32'hFFFFFFFF, 5'd0, 32'h0,        w); wsum += w;
        sc(OP_SRL,  32'h0, 32'hF0000000, 5'd4, 32'h0F000000, w); wsum += w;
        sc(OP_NOR,  32'h0, 32'h0,        5'd0, 32'hFFFFFFFF, w); wsum += w;
        chk("b2b_ready_waits", 32'(wsum), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;

        md(OP_MULT, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        sc(OP_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, w);
        sc(OP_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFA, w);

        md(OP_DIV,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        md(OP_DIVU, 32'h7,        32'h0,        32'h7,        32'hFFFFFFFF, 1'b0);
        md(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0);
        md(OP_DIV,  32'h7,        32'h0,        32'h7,        32'hFFFFFFFF, 1'b0);
        md(OP_DIV,  32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
        md(OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);

        // in_valid held through the busy window must yield a single accept
        md(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
        md(OP_MULTU, 32'h0, 32'h5, 32'h0, 32'h0, 1'b0);
        md(OP_MULTU, 32'h12345, 32'h10000, 32'h1, 32'h23450000, 1'b0);
        sc(OP_ADD, 32'h1, 32'h1, 5'd0, 32'h2, w);
        @(negedge clk);
        bus.in_valid = 1'b0;

        // reset in the middle of a divide
        send(OP_DIVU, 32'd100, 32'd7, 5'd0, 1'b0, dummy, w);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_hi",        bus.hi, 32'd0);
        chk("midrst_lo",        bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mhi = '0;
        mlo = '0;
        repeat (40) @(negedge clk);
        sc(OP_ADD, 32'h2, 32'h3, 5'd0, 32'h5, w);
        @(negedge clk);
        bus.in_valid = 1'b0;

        // WIDTH=16 instance: MULT FFFE*3 with WIDTH+2 latency
        @(negedge clk);
        bus16.alu_operation = OP_MULT;
        bus16.in1 = 16'hFFFE;
        bus16.in2 = 16'h0003;
        bus16.in_valid = 1'b1;
        chk("w16_in_ready", 32'(bus16.in_ready), 32'd1);
        @(posedge clk);
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            bus16.in_valid = 1'b0;
            if (bus16.out_valid === 1'b1) done = 1'b1;
            else n++;
        end
        chk("w16_latency", 32'(n), 32'd18);
        chk("w16_out", 32'(bus16.out), 32'h0000FFFA);
        chk("w16_hi",  32'(bus16.hi),  32'h0000FFFF);
        chk("w16_lo",  32'(bus16.lo),  32'h0000FFFA);

        repeat (5) @(negedge clk);
        chk("pending_expectations", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end
endmodule
